// File: rtl/riscv_pkg.sv
// Shared definitions for the five-stage RV32I-subset core: opcodes, ALU
// operations, pipeline register layouts and memory sizes.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int IMEM_WORDS = 1024;
  localparam int DMEM_WORDS = 256;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6f;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  // ID/EX contents; all-zero is a bubble with every enable cleared.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            src_imm;
    logic            src_pc;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            reg_we;
  } mem_wb_t;

  // funct3 to ALU operation; alt selects sub/sra (instruction bit 30).
  function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/riscv_decode.sv
// ID stage: instruction decode, immediate generation and register read.
// Unsupported encodings decode with every enable cleared, i.e. as a NOP.
module riscv_decode import riscv_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instruction,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [3:0]      alu_op,
  output logic            src_imm,
  output logic            src_pc,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic            is_branch,
  output logic            is_jal,
  output logic            is_jalr
);
  logic [6:0] f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  alu_op_t op;

  assign f7     = instruction[31:25];
  assign f3     = instruction[14:12];
  assign rd     = instruction[11:7];
  assign funct3 = f3;
  assign alu_op = op;
  assign imm_i  = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b  = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};

  // Control decode; anything not matched keeps the all-off defaults.
  always_comb begin
    op = ALU_ADD; imm = '0; src_imm = 1'b0; src_pc = 1'b0; reg_we = 1'b0;
    mem_re = 1'b0; mem_we = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    case (instruction[6:0])
      OP_REG: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        op = alu_from_funct3(f3, f7[5]); reg_we = 1'b1;
      end
      OP_IMM: if ((f3 != 3'd1 && f3 != 3'd5) || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20)) begin
        op = alu_from_funct3(f3, f3 == 3'd5 && f7[5]);
        imm = imm_i; src_imm = 1'b1; reg_we = 1'b1;
      end
      OP_LOAD: if (f3 == 3'd2) begin
        imm = imm_i; src_imm = 1'b1; mem_re = 1'b1; reg_we = 1'b1;
      end
      OP_STORE: if (f3 == 3'd2) begin
        imm = imm_s; src_imm = 1'b1; mem_we = 1'b1;
      end
      // beq/bne/blt/bge are exactly the funct3 codes with bit 1 clear.
      OP_BRANCH: if (!f3[1]) begin
        imm = imm_b; is_branch = 1'b1;
      end
      OP_JAL: begin
        imm = imm_j; is_jal = 1'b1; src_pc = 1'b1; reg_we = 1'b1;
      end
      OP_JALR: if (f3 == 3'd0) begin
        imm = imm_i; is_jalr = 1'b1; src_pc = 1'b1; reg_we = 1'b1;
      end
      default: ;
    endcase
  end

  riscv_reg_file reg_file (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (instruction[19:15]),
    .raddr2 (instruction[24:20]),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );
endmodule

// File: rtl/riscv_execute.sv
// EX stage: ALU, branch comparison and redirect target. Jumps run pc+4
// through the ALU so the link value travels down the normal result path.
module riscv_execute import riscv_pkg::*; (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      funct3,
  input  logic [3:0]      alu_op,
  input  logic            src_imm,
  input  logic            src_pc,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  output logic [XLEN-1:0] alu_result,
  output logic            branch_taken,
  output logic [XLEN-1:0] jump_target
);
  logic [XLEN-1:0] a, b;
  logic cond;

  assign a = src_pc ? pc : rs1_val;
  assign b = src_pc ? 32'd4 : (src_imm ? imm : rs2_val);

  // ALU; results wrap modulo 2^32.
  always_comb begin
    alu_result = '0;
    case (alu_op_t'(alu_op))
      ALU_ADD:  alu_result = a + b;
      ALU_SUB:  alu_result = a - b;
      ALU_SLL:  alu_result = a << b[4:0];
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  alu_result = a ^ b;
      ALU_SRL:  alu_result = a >> b[4:0];
      ALU_SRA:  alu_result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   alu_result = a | b;
      ALU_AND:  alu_result = a & b;
      default:  alu_result = '0;
    endcase
  end

  // Branch condition on the raw register operands.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'd0:    cond = (rs1_val == rs2_val);
      3'd1:    cond = (rs1_val != rs2_val);
      3'd4:    cond = ($signed(rs1_val) < $signed(rs2_val));
      3'd5:    cond = ($signed(rs1_val) >= $signed(rs2_val));
      default: cond = 1'b0;
    endcase
  end

  assign branch_taken = is_jal | is_jalr | (is_branch & cond);
  assign jump_target  = is_jalr ? ((rs1_val + imm) & ~32'd1) : (pc + imm);
endmodule

// File: rtl/riscv_fetch.sv
// IF stage: program counter plus instruction memory lookup.
module riscv_fetch import riscv_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instruction
);
  // PC advances by 4, or takes the EX redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              pc <= '0;
    else if (branch_taken) pc <= jump_target;
    else                   pc <= pc + 32'd4;
  end

  riscv_imem imem (
    .clk   (clk),
    .we    (1'b0),
    .waddr (10'd0),
    .wdata ('0),
    .addr  (pc[11:2]),
    .rdata (instruction)
  );
endmodule

// File: rtl/riscv_if_id.sv
// IF/ID pipeline register; reset and flush both load a NOP.
module riscv_if_id import riscv_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instruction_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instruction_out
);
  // Capture the fetched instruction or squash it on a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      pc_out          <= '0;
      instruction_out <= NOP;
    end else begin
      pc_out          <= pc_in;
      instruction_out <= instruction_in;
    end
  end
endmodule

// File: rtl/riscv_imem.sv
// Word-addressed instruction memory, combinational read, never cleared.
// The write port is normally tied off; program load is by hierarchical access.
module riscv_imem import riscv_pkg::*; (
  input  logic            clk,
  input  logic            we,
  input  logic [9:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [9:0]      addr,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] mem [0:IMEM_WORDS-1];

  // Optional synchronous write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/riscv_reg_file.sv
// 32 x XLEN register file: two read ports, one write port, x0 hardwired to
// zero, and write-through so a same-cycle read sees the value being written.
module riscv_reg_file import riscv_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);
  logic [XLEN-1:0] registers [0:31];

  // Clear on reset; writes to x0 are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      registers[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : (we && waddr == raddr1) ? wdata : registers[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : (we && waddr == raddr2) ? wdata : registers[raddr2];
endmodule

// File: rtl/riscv_processor.sv
// Five-stage in-order RV32I-subset core without hazard detection or
// forwarding. Branches and jumps resolve in EX and flush IF/ID and ID/EX.
module riscv_processor import riscv_pkg::*; (
  input logic clk,
  input logic rst
);
  logic            branch_taken;
  logic [XLEN-1:0] jump_target, alu_result;
  logic [XLEN-1:0] if_pc, if_instr, id_pc, id_instr, load_data;
  id_ex_t  id_d, id_q;
  ex_mem_t ex_q;
  mem_wb_t wb_q;
  logic [XLEN-1:0] dmem [0:DMEM_WORDS-1];

  riscv_fetch fetch_stage (
    .clk (clk), .rst (rst), .branch_taken (branch_taken),
    .jump_target (jump_target), .pc (if_pc), .instruction (if_instr)
  );

  riscv_if_id if_id_register (
    .clk (clk), .rst (rst), .flush (branch_taken), .pc_in (if_pc),
    .instruction_in (if_instr), .pc_out (id_pc), .instruction_out (id_instr)
  );

  assign id_d.pc = id_pc;

  riscv_decode decode_stage (
    .clk (clk), .rst (rst), .instruction (id_instr),
    .wb_we (wb_q.reg_we), .wb_rd (wb_q.rd), .wb_data (wb_q.data),
    .rs1_val (id_d.rs1_val), .rs2_val (id_d.rs2_val), .imm (id_d.imm),
    .rd (id_d.rd), .funct3 (id_d.funct3), .alu_op (id_d.alu_op),
    .src_imm (id_d.src_imm), .src_pc (id_d.src_pc), .reg_we (id_d.reg_we),
    .mem_re (id_d.mem_re), .mem_we (id_d.mem_we), .is_branch (id_d.is_branch),
    .is_jal (id_d.is_jal), .is_jalr (id_d.is_jalr)
  );

  // ID/EX register: bubble on reset or redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              id_q <= '0;
    else if (branch_taken) id_q <= '0;
    else                   id_q <= id_d;
  end

  riscv_execute execute_stage (
    .pc (id_q.pc), .rs1_val (id_q.rs1_val), .rs2_val (id_q.rs2_val),
    .imm (id_q.imm), .funct3 (id_q.funct3), .alu_op (id_q.alu_op),
    .src_imm (id_q.src_imm), .src_pc (id_q.src_pc), .is_branch (id_q.is_branch),
    .is_jal (id_q.is_jal), .is_jalr (id_q.is_jalr), .alu_result (alu_result),
    .branch_taken (branch_taken), .jump_target (jump_target)
  );

  // EX/MEM register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_q <= '0;
    else      ex_q <= '{result: alu_result, store_data: id_q.rs2_val, rd: id_q.rd,
                        reg_we: id_q.reg_we, mem_re: id_q.mem_re, mem_we: id_q.mem_we};
  end

  // Data memory store; word-indexed, low address bits ignored, never cleared.
  always_ff @(posedge clk) begin
    if (ex_q.mem_we) dmem[ex_q.result[9:2]] <= ex_q.store_data;
  end

  assign load_data = dmem[ex_q.result[9:2]];

  // MEM/WB register: select load data or ALU result for writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wb_q <= '0;
    else      wb_q <= '{data: ex_q.mem_re ? load_data : ex_q.result,
                        rd: ex_q.rd, reg_we: ex_q.reg_we};
  end
endmodule

// File: tb/tb_riscv_processor.sv
// Directed bench for riscv_processor: loads small programs into imem via
// hierarchical paths and checks pipeline/register state at fixed edges.
module tb_riscv_processor;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic clk;
  logic rst;
  int vectors;
  int miscompares;

  riscv_processor dut (.clk(clk), .rst(rst));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'd0, rd, 7'h13);
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  // Driver tasks
  task automatic put(input int idx, input logic [31:0] w);
    dut.fetch_stage.imem.mem[idx] = w;
  endtask
  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) dut.fetch_stage.imem.mem[i] = NOP_W;
  endtask
  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.decode_stage.reg_file.registers[i];
  endfunction

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;

    // Test 1: reset state, then addi x1,5 / addi x2,10 write-back timing
    clear_imem();
    put(0, addi(5'd1, 5'd0, 12'd5));
    put(1, addi(5'd2, 5'd0, 12'd10));
    step(1);
    check("reset_pc", dut.fetch_stage.pc, 32'd0);
    check("reset_ifid", dut.if_id_register.instruction_out, NOP_W);
    check("reset_x1", rf(1), 32'd0);
    release_reset();
    step(4);
    check("x1_before_e5", rf(1), 32'd0);
    step(1);
    check("x1_at_e5", rf(1), 32'd5);
    check("x2_before_e6", rf(2), 32'd0);
    check("pc_after_e5", dut.fetch_stage.pc, 32'd20);
    step(1);
    check("x2_at_e6", rf(2), 32'd10);

    // Test 2: R-type ops and stale reads on close dependences
    rst = 1'b0;
    clear_imem();
    put(0, addi(5'd1, 5'd0, 12'd5));
    put(1, addi(5'd2, 5'd0, 12'd10));
    put(4, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    put(5, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4));
    put(6, enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd5));
    put(7, enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd6));
    put(8, enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd7));
    put(9, enc_r(7'h00, 5'd1, 5'd1, 3'd1, 5'd8));
    put(10, enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd9));
    put(11, enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd10));
    put(12, addi(5'd11, 5'd0, 12'd7));
    put(13, addi(5'd12, 5'd11, 12'd0));
    put(14, addi(5'd13, 5'd11, 12'd0));
    put(15, addi(5'd14, 5'd11, 12'd0));
    release_reset();
    step(22);
    check("add_x3", rf(3), 32'd15);
    check("sub_x4", rf(4), 32'hFFFF_FFFB);
    check("and_x5", rf(5), 32'd0);
    check("or_x6", rf(6), 32'd15);
    check("xor_x7", rf(7), 32'd15);
    check("sll_x8", rf(8), 32'd160);
    check("srl_x9", rf(9), 32'd0);
    check("sra_x10", rf(10), 32'd0);
    check("dist1_stale_x12", rf(12), 32'd0);
    check("dist2_stale_x13", rf(13), 32'd0);
    check("dist3_ok_x14", rf(14), 32'd7);

    // Test 3: negative immediates, srai, compares
    rst = 1'b0;
    clear_imem();
    put(0, addi(5'd1, 5'd0, 12'hFF8));
    put(3, enc_i(12'h401, 5'd1, 3'd5, 5'd2, 7'h13));
    put(4, enc_i(12'd1, 5'd1, 3'd3, 5'd3, 7'h13));
    put(5, enc_i(12'd0, 5'd1, 3'd2, 5'd4, 7'h13));
    put(6, enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd5));
    release_reset();
    step(12);
    check("addi_neg_x1", rf(1), 32'hFFFF_FFF8);
    check("srai_x2", rf(2), 32'hFFFF_FFFC);
    check("sltiu_x3", rf(3), 32'd0);
    check("slti_x4", rf(4), 32'd1);
    check("sltu_x5", rf(5), 32'd1);

    // Test 4: branches and jumps
    rst = 1'b0;
    clear_imem();
    put(0, enc_b(13'd12, 5'd0, 5'd0, 3'd0));
    put(1, addi(5'd5, 5'd0, 12'd1));
    put(2, addi(5'd5, 5'd0, 12'd1));
    put(3, addi(5'd6, 5'd0, 12'd3));
    put(4, enc_j(21'd8, 5'd7));
    put(5, addi(5'd8, 5'd0, 12'd1));
    put(6, addi(5'd9, 5'd0, 12'd9));
    put(7, enc_b(13'd8, 5'd0, 5'd0, 3'd1));
    put(8, addi(5'd10, 5'd0, 12'd4));
    put(9, enc_i(12'd48, 5'd0, 3'd0, 5'd11, 7'h67));
    put(10, addi(5'd12, 5'd0, 12'd1));
    put(11, addi(5'd12, 5'd0, 12'd1));
    put(12, addi(5'd13, 5'd0, 12'd13));
    release_reset();
    step(2);
    check("beq_taken", 32'(dut.execute_stage.branch_taken), 32'd1);
    check("beq_target", dut.execute_stage.jump_target, 32'd12);
    step(1);
    check("beq_pc", dut.fetch_stage.pc, 32'd12);
    check("beq_flush_ifid", dut.if_id_register.instruction_out, NOP_W);
    step(3);
    check("jal_taken", 32'(dut.execute_stage.branch_taken), 32'd1);
    check("jal_target", dut.execute_stage.jump_target, 32'd24);
    check("jal_link", dut.execute_stage.alu_result, 32'd20);
    step(4);
    check("bne_not_taken", 32'(dut.execute_stage.branch_taken), 32'd0);
    step(2);
    check("jalr_taken", 32'(dut.execute_stage.branch_taken), 32'd1);
    check("jalr_target", dut.execute_stage.jump_target, 32'd48);
    step(10);
    check("beq_skip_x5", rf(5), 32'd0);
    check("beq_dest_x6", rf(6), 32'd3);
    check("jal_rd_x7", rf(7), 32'd20);
    check("jal_skip_x8", rf(8), 32'd0);
    check("jal_dest_x9", rf(9), 32'd9);
    check("bne_fall_x10", rf(10), 32'd4);
    check("jalr_rd_x11", rf(11), 32'd40);
    check("jalr_skip_x12", rf(12), 32'd0);
    check("jalr_dest_x13", rf(13), 32'd13);

    // Test 5: store/load round trip, misaligned load address
    rst = 1'b0;
    clear_imem();
    put(0, addi(5'd1, 5'd0, 12'd123));
    put(3, enc_s(12'd8, 5'd1, 5'd0));
    put(5, addi(5'd2, 5'd0, 12'd77));
    put(6, enc_i(12'd8, 5'd0, 3'd2, 5'd6, 7'h03));
    put(7, addi(5'd7, 5'd0, 12'd1));
    put(8, enc_i(12'd11, 5'd0, 3'd2, 5'd8, 7'h03));
    release_reset();
    step(16);
    check("lw_x6", rf(6), 32'd123);
    check("lw_misaligned_x8", rf(8), 32'd123);
    check("after_load_x7", rf(7), 32'd1);
    check("addi_x2", rf(2), 32'd77);

    // Test 6: reset asserted mid-program
    rst = 1'b0;
    release_reset();
    step(7);
    check("mid_ifid_lw", dut.if_id_register.instruction_out, enc_i(12'd8, 5'd0, 3'd2, 5'd6, 7'h03));
    check("mid_ex_result", dut.execute_stage.alu_result, 32'd77);
    check("mid_x1", rf(1), 32'd123);
    rst = 1'b0;
    #1;
    check("rst_pc", dut.fetch_stage.pc, 32'd0);
    check("rst_ifid", dut.if_id_register.instruction_out, NOP_W);
    check("rst_ex_result", dut.execute_stage.alu_result, 32'd0);
    check("rst_x1", rf(1), 32'd0);

    // Test 7: dmem survives reset
    clear_imem();
    put(0, enc_i(12'd8, 5'd0, 3'd2, 5'd6, 7'h03));
    release_reset();
    step(6);
    check("dmem_kept_x6", rf(6), 32'd123);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/riscv_processor.md
# riscv_processor

Five-stage in-order RV32I-subset pipelined CPU core (IF, ID, EX, MEM, WB) with internal instruction memory, data memory and register file. It is the top of the CPU hierarchy and has no bus or I/O ports. Program load and observation use fixed hierarchical paths. There is no hazard detection or forwarding: software separates dependent instructions with NOPs. Branches and jumps resolve in EX.

## Interface
- No parameters.
- Constants:
  - XLEN = 32.
  - IMEM_WORDS = 1024.
  - DMEM_WORDS = 256.
  - NOP = 32'h00000013.
- clk: input, 1 bit. Single clock; all state updates on the rising edge.
- rst: input, 1 bit. Asynchronous, active-low reset.
- Hierarchical names, mandatory for bench access:
  - fetch_stage.pc
  - fetch_stage.imem.mem[0:1023]
  - if_id_register.instruction_out
  - decode_stage.reg_file.registers[0:31]
  - execute_stage.alu_result
  - execute_stage.branch_taken
  - execute_stage.jump_target

## Operation
- Supported instructions:
  - R-type: add, sub, sll, slt, sltu, xor, srl, sra, or, and.
  - I-type ALU: addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - Memory: lw, sw.
  - Control: beq, bne, blt, bge, jal, jalr.
  - Anything else executes as NOP.
- Shifts use rs2[4:0] or shamt. sra and srai are arithmetic. All arithmetic wraps modulo 2^32.
- imem:
  - Word-indexed by pc[11:2], combinational read.
  - Not cleared by reset; contents may be written at any time by the bench.
  - Out-of-range pc wraps on pc[11:2].
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Written on the rising edge from WB.
  - Write-through: an ID read of the register being written in the same cycle returns the new value.
- Hazards:
  - RAW distance of 3 or more instructions is correct.
  - Closer dependences return stale values and are not corrected.
- EX stage:
  - Computes alu_result.
  - Computes jump_target: pc+imm for branches and jal; (rs1+imm)&~1 for jalr.
  - Computes branch_taken: 1 for a taken branch or any jump.
- On branch_taken:
  - The next pc is jump_target.
  - IF/ID and ID/EX are flushed to NOP, giving a 2-cycle penalty.
  - jal and jalr write pc+4 to rd.
- Data memory:
  - lw reads dmem[addr[9:2]].
  - sw writes at the rising edge in MEM.
  - Misaligned low bits are ignored.

## Timing
- While rst=0:
  - pc=0.
  - All pipeline registers hold NOP with write-enable cleared.
  - registers[1..31]=0.
  - dmem is not cleared.
- First fetch is at pc=0 in the cycle after rst rises.
- An instruction fetched in cycle n (its IF cycle):
  - is in ID in n+1, EX in n+2, MEM in n+3;
  - writes rd at the rising edge that ends cycle n+4.
  - The write is visible in registers[] after that edge.
- pc advances by 4 per cycle unless branch_taken.
- The redirect takes effect at the edge ending the EX cycle.
- Reset asserted mid-program: the pipeline returns to NOP state immediately, and pc=0 without a clock edge.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants;
  - ALU operation enum;
  - NOP;
  - IMEM_WORDS and DMEM_WORDS.
- Required instances, names fixed as above:
  - fetch_stage, containing imem;
  - if_id_register;
  - decode_stage, containing reg_file;
  - execute_stage;
  - ID/EX, EX/MEM and MEM/WB registers;
  - memory and writeback logic.
- Natural separately reusable sub-module: reg_file (2 read ports, 1 write port, write-through).

## Test plan
- Reset held for 10 time units, then program addi x1,x0,5; addi x2,x0,10 followed by 5 NOPs:
  - registers[1]=5 and registers[2]=10 after 5 and 6 edges respectively.
- add x3,x1,x2 and sub x4,x1,x2, padded -> x3=15, x4=32'hFFFFFFFB.
- and, or, xor, sll x8,x1,x1, srl, sra into x5–x10, padded -> x5=0, x6=15, x7=15, x8=160, x9=0, x10=0.
- addi x1,x0,-8; srai x2,x1,1; sltiu x3,x1,1 -> x2=32'hFFFFFFFC, x3=0.
- beq x0,x0,+12 followed by addi x5,x0,1 ×2 -> branch_taken=1 with jump_target=pc+12 in EX; x5 stays 0; jal writes pc+4 to rd.
- sw x1,8(x0) then, after padding, lw x6,8(x0) -> x6 equals x1. Assert rst mid-program -> pc=0 and pipeline holds NOPs immediately, and registers are cleared.
